// File: rtl/calc_pkg.sv
// calc_pkg: shared constants for pipelined_calculator and calc_alu.
//   OPW            : opcode width (Ctrl port width)
//   OP_ADD..OP_EQ  : ALU opcodes; codes 13-15 are reserved and produce 0
package calc_pkg;

    localparam int OPW = 4;

    localparam logic [OPW-1:0] OP_ADD = 4'd0;
    localparam logic [OPW-1:0] OP_SUB = 4'd1;
    localparam logic [OPW-1:0] OP_AND = 4'd2;
    localparam logic [OPW-1:0] OP_OR  = 4'd3;
    localparam logic [OPW-1:0] OP_NOT = 4'd4;
    localparam logic [OPW-1:0] OP_XOR = 4'd5;
    localparam logic [OPW-1:0] OP_NOR = 4'd6;
    localparam logic [OPW-1:0] OP_SHL = 4'd7;
    localparam logic [OPW-1:0] OP_SHR = 4'd8;
    localparam logic [OPW-1:0] OP_ASR = 4'd9;
    localparam logic [OPW-1:0] OP_ROL = 4'd10;
    localparam logic [OPW-1:0] OP_ROR = 4'd11;
    localparam logic [OPW-1:0] OP_EQ  = 4'd12;

endpackage

// File: rtl/calc_alu.sv
// calc_alu: purely combinational ALU of the pipelined calculator.
// Ports:
//   ctrl  in  OPW  opcode (see calc_pkg)
//   x     in  DW   first operand; x[log2(DW)-1:0] is also the shift amount
//   y     in  DW   second operand
//   out   out DW   result
//   carry out 1    carry out of ADD/SUB, 0 for every other opcode
module calc_alu
    import calc_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [OPW-1:0] ctrl,
    input  logic [DW-1:0]  x,
    input  logic [DW-1:0]  y,
    output logic [DW-1:0]  out,
    output logic           carry
);

    localparam int SW = $clog2(DW);

    logic [DW:0]   sum_s;
    logic [SW-1:0] sh_s;

    // Opcode decode; subtraction is x + ~y + 1 so carry means "no borrow"
    always_comb begin
        sum_s = {(DW+1){1'b0}};
        sh_s  = x[SW-1:0];
        out   = {DW{1'b0}};
        carry = 1'b0;
        case (ctrl)
            OP_ADD: begin
                sum_s = {1'b0, x} + {1'b0, y};
                out   = sum_s[DW-1:0];
                carry = sum_s[DW];
            end
            OP_SUB: begin
                sum_s = {1'b0, x} + {1'b0, ~y} + {{DW{1'b0}}, 1'b1};
                out   = sum_s[DW-1:0];
                carry = sum_s[DW];
            end
            OP_AND: out = x & y;
            OP_OR:  out = x | y;
            OP_NOT: out = ~x;
            OP_XOR: out = x ^ y;
            OP_NOR: out = ~(x | y);
            OP_SHL: out = y << sh_s;
            OP_SHR: out = y >> sh_s;
            OP_ASR: out = {x[DW-1], x[DW-1:1]};
            OP_ROL: out = {x[DW-2:0], x[DW-1]};
            OP_ROR: out = {x[0], x[DW-1:1]};
            OP_EQ:  out = (x == y) ? {{(DW-1){1'b0}}, 1'b1} : {DW{1'b0}};
            default: out = {DW{1'b0}};
        endcase
    end

endmodule

// File: rtl/pipelined_calculator.sv
// pipelined_calculator: two-stage calculator with a 2**AW x DW register file.
//   Stage 1 latches operands of an accepted instruction; stage 2 computes,
//   writes back (R0 is hardwired to 0) and presents result/Carry on a
//   valid/ready output with backpressure.
// Ports:
//   Clk, Rst            clock, synchronous active-high reset
//   in_valid/in_ready   instruction handshake
//   WEN, RW, RX, RY     writeback enable/register, operand registers
//   DataIn, Sel, Ctrl   immediate, result select (1: ALU), ALU opcode
//   out_valid/out_ready result handshake
//   result, Carry       instruction result and carry flag
// Build option:
//   CALC_FWD_EN defined  : stage-2 result bypassed into the operand latch
//   CALC_FWD_EN undefined: one-cycle interlock on a read-after-write match
module pipelined_calculator
    import calc_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic           Clk,
    input  logic           Rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           WEN,
    input  logic [AW-1:0]  RW,
    input  logic [AW-1:0]  RX,
    input  logic [AW-1:0]  RY,
    input  logic [DW-1:0]  DataIn,
    input  logic           Sel,
    input  logic [OPW-1:0] Ctrl,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [DW-1:0]  result,
    output logic           Carry
);

    localparam int NREG = 2**AW;

    logic [DW-1:0]  regs_q [NREG];
    logic [DW-1:0]  regs_d [NREG];

    logic           s1_valid_q, s1_valid_d;
    logic [DW-1:0]  s1_x_q, s1_x_d;
    logic [DW-1:0]  s1_y_q, s1_y_d;
    logic [DW-1:0]  s1_data_q, s1_data_d;
    logic           s1_sel_q, s1_sel_d;
    logic [OPW-1:0] s1_ctrl_q, s1_ctrl_d;
    logic           s1_wen_q, s1_wen_d;
    logic [AW-1:0]  s1_rw_q, s1_rw_d;

    logic           out_valid_q, out_valid_d;
    logic [DW-1:0]  result_q, result_d;
    logic           carry_q, carry_d;

    logic           adv_s;
    logic           hit_x_s, hit_y_s;
    logic           in_ready_s;
    logic           accept_s;
    logic           wb_en_s;
    logic [DW-1:0]  alu_out_s;
    logic           alu_carry_s;
    logic [DW-1:0]  s2_res_s;
    logic           s2_carry_s;
    logic [DW-1:0]  op_x_s, op_y_s;

    calc_alu #(.DW(DW)) u_alu (
        .ctrl  (s1_ctrl_q),
        .x     (s1_x_q),
        .y     (s1_y_q),
        .out   (alu_out_s),
        .carry (alu_carry_s)
    );

    // Pipeline advance, RAW match against stage 1, accept and writeback enables
    always_comb begin
        adv_s   = !out_valid_q || out_ready;
        hit_x_s = s1_valid_q && s1_wen_q && (s1_rw_q != {AW{1'b0}}) && (s1_rw_q == RX);
        hit_y_s = s1_valid_q && s1_wen_q && (s1_rw_q != {AW{1'b0}}) && (s1_rw_q == RY);
`ifdef CALC_FWD_EN
        in_ready_s = adv_s && !Rst;
`else
        // Hold the dependent instruction one cycle so it reads the landed value
        in_ready_s = adv_s && !Rst && !(hit_x_s || hit_y_s);
`endif
        accept_s = in_valid && in_ready_s;
        wb_en_s  = adv_s && s1_valid_q && s1_wen_q && (s1_rw_q != {AW{1'b0}});
    end

    assign in_ready = in_ready_s;

    // Stage-2 result: ALU output or immediate pass-through
    always_comb begin
        if (s1_sel_q) begin
            s2_res_s   = alu_out_s;
            s2_carry_s = alu_carry_s;
        end else begin
            s2_res_s   = s1_data_q;
            s2_carry_s = 1'b0;
        end
    end

    // Operand fetch; with forwarding a match takes the value being written back
    always_comb begin
`ifdef CALC_FWD_EN
        if (hit_x_s) begin
            op_x_s = s2_res_s;
        end else begin
            op_x_s = regs_q[RX];
        end
        if (hit_y_s) begin
            op_y_s = s2_res_s;
        end else begin
            op_y_s = regs_q[RY];
        end
`else
        op_x_s = regs_q[RX];
        op_y_s = regs_q[RY];
`endif
    end

    // Stage-1 next state: load on accept, empty when it drains, else hold
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_x_d     = s1_x_q;
        s1_y_d     = s1_y_q;
        s1_data_d  = s1_data_q;
        s1_sel_d   = s1_sel_q;
        s1_ctrl_d  = s1_ctrl_q;
        s1_wen_d   = s1_wen_q;
        s1_rw_d    = s1_rw_q;
        if (accept_s) begin
            s1_valid_d = 1'b1;
            s1_x_d     = op_x_s;
            s1_y_d     = op_y_s;
            s1_data_d  = DataIn;
            s1_sel_d   = Sel;
            s1_ctrl_d  = Ctrl;
            s1_wen_d   = WEN;
            s1_rw_d    = RW;
        end else if (adv_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Output stage next state: load stage-2 result on advance, else hold
    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        carry_d     = carry_q;
        if (adv_s) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                result_d = s2_res_s;
                carry_d  = s2_carry_s;
            end else begin
                result_d = result_q;
                carry_d  = carry_q;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Register file next state: single writeback on the transfer edge, R0 pinned to 0
    always_comb begin
        regs_d = regs_q;
        if (wb_en_s) begin
            regs_d[s1_rw_q] = s2_res_s;
        end else begin
            regs_d[s1_rw_q] = regs_q[s1_rw_q];
        end
        regs_d[0] = {DW{1'b0}};
    end

    // State registers with synchronous reset; reset discards in-flight work
    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= {DW{1'b0}};
            end
            s1_valid_q  <= 1'b0;
            s1_x_q      <= {DW{1'b0}};
            s1_y_q      <= {DW{1'b0}};
            s1_data_q   <= {DW{1'b0}};
            s1_sel_q    <= 1'b0;
            s1_ctrl_q   <= {OPW{1'b0}};
            s1_wen_q    <= 1'b0;
            s1_rw_q     <= {AW{1'b0}};
            out_valid_q <= 1'b0;
            result_q    <= {DW{1'b0}};
            carry_q     <= 1'b0;
        end else begin
            regs_q      <= regs_d;
            s1_valid_q  <= s1_valid_d;
            s1_x_q      <= s1_x_d;
            s1_y_q      <= s1_y_d;
            s1_data_q   <= s1_data_d;
            s1_sel_q    <= s1_sel_d;
            s1_ctrl_q   <= s1_ctrl_d;
            s1_wen_q    <= s1_wen_d;
            s1_rw_q     <= s1_rw_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign Carry     = carry_q;

endmodule

// File: tb/tb_pipelined_calculator.sv
// Self-checking bench for pipelined_calculator (DW=8, AW=3).
// An in-order architectural model (each instruction sees all earlier
// writebacks) predicts every result; a negedge monitor compares each valid
// output against the head of the expected queue.
module tb_pipelined_calculator;

    localparam int DW = 8;
    localparam int AW = 3;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          in_valid;
    logic          in_ready;
    logic          WEN;
    logic [AW-1:0] RW, RX, RY;
    logic [DW-1:0] DataIn;
    logic          Sel;
    logic [3:0]    Ctrl;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] result;
    logic          Carry;

    int checks = 0;
    int errors = 0;

    logic [7:0] mregs [8];
    logic [8:0] expq [$];
    logic [8:0] last_exp;

    bit   rand_ready   = 1'b0;
    logic forced_ready = 1'b1;
    logic rnd_bit      = 1'b0;

    assign out_ready = rand_ready ? rnd_bit : forced_ready;

    always #5 Clk = ~Clk;

    pipelined_calculator #(.DW(DW), .AW(AW)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .WEN       (WEN),
        .RW        (RW),
        .RX        (RX),
        .RY        (RY),
        .DataIn    (DataIn),
        .Sel       (Sel),
        .Ctrl      (Ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .Carry     (Carry)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: {carry, result} from plain integer arithmetic
    function automatic logic [8:0] ref_calc(input logic sel, input logic [3:0] op,
                                            input logic [7:0] d, input logic [7:0] x,
                                            input logic [7:0] y);
        int a, b, r;
        logic c;
        a = int'(x);
        b = int'(y);
        r = 0;
        c = 1'b0;
        if (!sel) return {1'b0, d};
        case (op)
            4'd0:  begin r = a + b; c = (r > 255); end
            4'd1:  begin r = a + (255 - b) + 1; c = (r > 255); end
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = 255 - a;
            4'd5:  r = a ^ b;
            4'd6:  r = 255 - (a | b);
            4'd7:  r = b << (a % 8);
            4'd8:  r = b >> (a % 8);
            4'd9:  r = a / 2 + ((a >= 128) ? 128 : 0);
            4'd10: r = (a * 2) % 256 + a / 128;
            4'd11: r = a / 2 + (a % 2) * 128;
            4'd12: r = (a == b) ? 1 : 0;
            default: r = 0;
        endcase
        return {c, 8'(r % 256)};
    endfunction

    // Monitor: inputs are stable between posedge+1 and the next posedge
    always @(negedge Clk) begin
        logic [8:0] e;
        if (Rst) begin
            chk("in_ready_in_reset", 32'(in_ready), 32'd0);
            expq.delete();
            for (int i = 0; i < 8; i++) mregs[i] = 8'h00;
        end else begin
            if (out_valid === 1'b1) begin
                if (expq.size() == 0) begin
                    chk("spurious_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    chk("result_carry", 32'({Carry, result}), 32'(expq[0]));
                    if (out_ready) void'(expq.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                e = ref_calc(Sel, Ctrl, DataIn, mregs[RX], mregs[RY]);
                expq.push_back(e);
                last_exp = e;
                if (WEN && RW != 3'd0) mregs[RW] = e[7:0];
            end
        end
    end

    initial begin
        forever begin
            @(posedge Clk);
            #1;
            rnd_bit = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // Present an instruction (called at posedge+1); returns cycles stalled
    task automatic issue(input logic wen, input logic [2:0] rw, input logic [2:0] rx,
                         input logic [2:0] ry, input logic [7:0] d, input logic sel,
                         input logic [3:0] op, output int stalls);
        bit acc;
        int n;
        WEN = wen; RW = rw; RX = rx; RY = ry; DataIn = d; Sel = sel; Ctrl = op;
        in_valid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 60) begin
            @(negedge Clk);
            acc = in_ready;
            @(posedge Clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        stalls = n - 1;
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (expq.size() != 0 && n < 200) begin
            @(posedge Clk);
            n++;
        end
        #1;
        if (expq.size() != 0) chk("drain_timeout", 32'(expq.size()), 32'd0);
    endtask

    initial begin
        int st, st1, st2, exp_stall;
        Rst = 1'b1; in_valid = 1'b0; WEN = 1'b0; RW = 3'd0; RX = 3'd0; RY = 3'd0;
        DataIn = 8'h00; Sel = 1'b0; Ctrl = 4'd0;
        repeat (2) @(posedge Clk);
        #1;
        @(negedge Clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge Clk); #1;
        Rst = 1'b0;
        @(negedge Clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_carry", 32'(Carry), 32'd0);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge Clk); #1;

        // Loads and ADD with latency
        issue(1'b1, 3'd1, 3'd0, 3'd0, 8'h0F, 1'b0, 4'd0, st);
        issue(1'b1, 3'd2, 3'd0, 3'd0, 8'hF1, 1'b0, 4'd0, st);
        drain();
        issue(1'b1, 3'd3, 3'd1, 3'd2, 8'h00, 1'b1, 4'd0, st);
        chk("add_model", 32'(last_exp), 32'h100);
        @(negedge Clk);
        chk("add_lat_early", 32'(out_valid), 32'd0);
        @(negedge Clk);
        chk("add_lat_valid", 32'(out_valid), 32'd1);
        chk("add_dut", 32'({Carry, result}), 32'h100);
        @(posedge Clk); #1;
        issue(1'b0, 3'd0, 3'd3, 3'd0, 8'h00, 1'b1, 4'd3, st);
        chk("read_r3_model", 32'(last_exp), 32'h000);
        drain();

        // Back-to-back dependent SUB then XOR
        issue(1'b1, 3'd4, 3'd2, 3'd1, 8'h00, 1'b1, 4'd1, st1);
        chk("sub_model", 32'(last_exp), 32'h1E2);
        issue(1'b1, 3'd5, 3'd4, 3'd1, 8'h00, 1'b1, 4'd5, st2);
        chk("xor_model", 32'(last_exp), 32'h0ED);
`ifdef CALC_FWD_EN
        exp_stall = 0;
`else
        exp_stall = 1;
`endif
        chk("raw_stall_cycles", 32'(st1 + st2), 32'(exp_stall));
        drain();

        // Backpressure: hold out_ready low for three cycles
        forced_ready = 1'b0;
        issue(1'b1, 3'd6, 3'd0, 3'd0, 8'h5A, 1'b0, 4'd0, st);
        issue(1'b1, 3'd7, 3'd1, 3'd2, 8'h00, 1'b1, 4'd2, st);
        chk("and_model", 32'(last_exp), 32'h001);
        WEN = 1'b1; RW = 3'd3; RX = 3'd1; RY = 3'd2; DataIn = 8'h00; Sel = 1'b1; Ctrl = 4'd5;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge Clk);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_result", 32'(result), 32'h5A);
        end
        @(posedge Clk); #1;
        forced_ready = 1'b1;
        issue(1'b1, 3'd3, 3'd1, 3'd2, 8'h00, 1'b1, 4'd5, st);
        chk("bp_xor_model", 32'(last_exp), 32'h0FE);
        issue(1'b0, 3'd0, 3'd7, 3'd0, 8'h00, 1'b1, 4'd3, st);
        chk("read_r7_model", 32'(last_exp), 32'h001);
        drain();

        // R0 is read-only zero
        issue(1'b1, 3'd0, 3'd0, 3'd0, 8'hAA, 1'b0, 4'd0, st);
        issue(1'b1, 3'd6, 3'd0, 3'd0, 8'h00, 1'b1, 4'd3, st);
        chk("r0_or_model", 32'(last_exp), 32'h000);
        drain();

        // Shifts/rotates with x=03, y=81
        issue(1'b1, 3'd1, 3'd0, 3'd0, 8'h03, 1'b0, 4'd0, st);
        issue(1'b1, 3'd2, 3'd0, 3'd0, 8'h81, 1'b0, 4'd0, st);
        drain();
        issue(1'b0, 3'd0, 3'd1, 3'd2, 8'h00, 1'b1, 4'd7, st);
        chk("shl_model", 32'(last_exp), 32'h008);
        issue(1'b0, 3'd0, 3'd1, 3'd2, 8'h00, 1'b1, 4'd8, st);
        chk("shr_model", 32'(last_exp), 32'h010);
        issue(1'b0, 3'd0, 3'd2, 3'd2, 8'h00, 1'b1, 4'd9, st);
        chk("asr_model", 32'(last_exp), 32'h0C0);
        issue(1'b0, 3'd0, 3'd2, 3'd2, 8'h00, 1'b1, 4'd10, st);
        chk("rol_model", 32'(last_exp), 32'h003);
        issue(1'b0, 3'd0, 3'd2, 3'd2, 8'h00, 1'b1, 4'd11, st);
        chk("ror_model", 32'(last_exp), 32'h0C0);
        issue(1'b0, 3'd0, 3'd2, 3'd2, 8'h00, 1'b1, 4'd12, st);
        chk("eq_model", 32'(last_exp), 32'h001);
        issue(1'b0, 3'd0, 3'd1, 3'd2, 8'h00, 1'b1, 4'd6, st);
        chk("nor_model", 32'(last_exp), 32'h07C);
        issue(1'b0, 3'd0, 3'd1, 3'd2, 8'h00, 1'b1, 4'd13, st);
        chk("rsvd_model", 32'(last_exp), 32'h000);
        drain();

        // Randomised traffic with random backpressure
        rand_ready = 1'b1;
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge Clk); #1;
            end
            issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), st);
        end
        rand_ready = 1'b0;
        forced_ready = 1'b1;
        drain();

        // Reset while S1 and the output both hold instructions
        forced_ready = 1'b0;
        issue(1'b1, 3'd5, 3'd0, 3'd0, 8'h77, 1'b0, 4'd0, st);
        issue(1'b1, 3'd6, 3'd0, 3'd0, 8'h66, 1'b0, 4'd0, st);
        Rst = 1'b1;
        @(negedge Clk);
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        @(posedge Clk); #1;
        Rst = 1'b0;
        @(negedge Clk);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_result", 32'({Carry, result}), 32'h000);
        chk("flush_model_r6", 32'(mregs[6]), 32'h00);
        @(posedge Clk); #1;
        forced_ready = 1'b1;
        for (int k = 1; k < 8; k++) begin
            issue(1'b0, 3'd0, 3'(k), 3'd0, 8'h00, 1'b1, 4'd3, st);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
